// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Dot-product accumulate stage that feeds the activation unit. It takes a
// stream of signed INT8 (activation, weight) pairs over a valid/ready
// handshake and sums their products in a wide signed accumulator. At the end
// of each vector it emits one result, saturated to signed OUT_W bits, as a
// single-cycle strobe.
//
// Optional feature (compile-time macro ACC_BIAS_EN):
//   When defined, the module has an extra port bias_in. It is sampled on an
//   accepted start and preloads the accumulator, so saturation applies to the
//   bias+sum total. When undefined, the accumulator starts from zero and the
//   port does not exist.
//
// Parameters
//   ACC_W     internal accumulator width (>= 24, so 255 x 16384 cannot wrap)
//   OUT_W     result width and saturation target
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a new vector; honoured only in IDLE
//   vec_len    in   8      number of pairs, sampled on accepted start (0 ok)
//   in_valid   in   1      a_in / w_in carry a pair
//   in_ready   out  1      stage accepts a pair this cycle (high in ACCUM)
//   a_in       in   8      signed activation operand
//   w_in       in   8      signed weight operand
//   bias_in    in   16     signed bias (ACC_BIAS_EN builds only)
//   acc_valid  out  1      one-cycle result strobe (activation-unit enable)
//   acc_out    out  OUT_W  signed saturated result, held until the next one
//   acc_ovf    out  1      result was clamped; qualified by acc_valid
//   busy       out  1      FSM is not in IDLE
// -----------------------------------------------------------------------------
module mac_accumulator #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              vec_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              a_in,
  input  logic [7:0]              w_in,
`ifdef ACC_BIAS_EN
  input  logic [15:0]             bias_in,
`endif
  output logic                    acc_valid,
  output logic signed [OUT_W-1:0] acc_out,
  output logic                    acc_ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]                count_q, count_d;
  logic [7:0]                len_q, len_d;
  logic signed [OUT_W-1:0]   acc_out_q, acc_out_d;
  logic                      ovf_q, ovf_d;

  logic signed [15:0]        prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_init;
  logic                      last_pair;
  logic [OUT_W:0]            sat_res;

  // Signed 8x8 product. Both operands are cast so the multiply is signed and
  // evaluated at 16 bits, which holds every result including -128 * -128.
  assign prod     = $signed(a_in) * $signed(w_in);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};

`ifdef ACC_BIAS_EN
  assign acc_init = {{(ACC_W-16){bias_in[15]}}, bias_in};
`else
  assign acc_init = '0;
`endif

  // len_q is at least 1 whenever the FSM is in ACCUM, so len_q - 1 cannot
  // underflow when it is used.
  assign last_pair = (count_q == (len_q - 8'd1));

  // Clamp to signed OUT_W. The value fits only when every bit from the MSB
  // down to bit OUT_W-1 is equal. Otherwise the sign bit picks the rail.
  // Result layout: {ovf, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] upper;
    upper = v[ACC_W-1:OUT_W-1];
    if ((&upper) || (~|upper)) begin
      saturate = {1'b0, v[OUT_W-1:0]};
    end else if (v[ACC_W-1]) begin
      saturate = {1'b1, SAT_MIN};
    end else begin
      saturate = {1'b1, SAT_MAX};
    end
  endfunction

  assign sat_res = saturate(acc_d);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement. A path
    // that leaves one unassigned would infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = vec_len;
          count_d = '0;
          acc_d   = acc_init;
          state_d = (vec_len == 8'd0) ? S_OUTPUT : S_ACCUM;
        end
      end

      S_ACCUM: begin
        // in_ready is 1 throughout ACCUM, so in_valid alone means an accept.
        if (in_valid) begin
          acc_d   = acc_q + prod_ext;
          count_d = count_q + 8'd1;
          if (last_pair) begin
            state_d = S_OUTPUT;
          end
        end
      end

      S_OUTPUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Register the result on the edge that enters OUTPUT. This makes
    // acc_out / acc_ovf valid in the same cycle as the acc_valid strobe, and
    // they then hold until the next OUTPUT.
    if ((state_d == S_OUTPUT) && (state_q != S_OUTPUT)) begin
      {ovf_d, acc_out_d} = sat_res;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // read the old values of the others on the same edge, whatever the order of
  // the statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      len_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      len_q     <= len_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  // Control outputs are decodes of the state register, so they stay glitch
  // free and change only on a clock edge.
  assign in_ready  = (state_q == S_ACCUM);
  assign acc_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_out_q;
  assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Directed self-checking bench for mac_accumulator. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
// Expected results are hand-computed constants. Bias vectors are compiled in
// only when ACC_BIAS_EN is defined.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         vec_len;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         a_in;
  logic [7:0]         w_in;
  logic               acc_valid;
  logic signed [15:0] acc_out;
  logic               acc_ovf;
  logic               busy;
`ifdef ACC_BIAS_EN
  logic [15:0]        bias_in;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] a_vec [8];
  logic [7:0] w_vec [8];

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24), .OUT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .w_in      (w_in),
`ifdef ACC_BIAS_EN
    .bias_in   (bias_in),
`endif
    .acc_valid (acc_valid),
    .acc_out   (acc_out),
    .acc_ovf   (acc_ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input int idx, input int a, input int w);
    a_vec[idx] = a[7:0];
    w_vec[idx] = w[7:0];
  endtask

  // Runs one vector from IDLE and returns at the falling edge after the
  // OUTPUT cycle (back in IDLE). gap inserts an idle cycle between pairs.
  // poke pulses start (with vec_len=0) during ACCUM and during OUTPUT; both
  // pulses must be ignored.
  task automatic run_vector(input string tag, input int len, input bit gap,
                            input bit poke, input int exp_out, input int exp_ovf);
    start   = 1'b1;
    vec_len = len[7:0];
    @(negedge clk);
    start   = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int i = 0; i < len; i++) begin
      if (gap && i > 0) @(negedge clk);
      check($sformatf("%s_rdy%0d", tag, i), in_ready, 1);
      check($sformatf("%s_nov%0d", tag, i), acc_valid, 0);
      in_valid = 1'b1;
      a_in     = a_vec[i];
      w_in     = w_vec[i];
      if (poke && i == 1) begin
        start   = 1'b1;
        vec_len = 8'd0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    // One cycle after the last accept (or after start when len == 0).
    check({tag, "_valid"}, acc_valid, 1);
    check({tag, "_out"},   acc_out,   exp_out);
    check({tag, "_ovf"},   acc_ovf,   exp_ovf);
    check({tag, "_rdy_o"}, in_ready,  0);
    if (poke) begin
      start   = 1'b1;
      vec_len = 8'd3;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_pulse"}, acc_valid, 0);
    check({tag, "_idle"},  busy,      0);
    check({tag, "_hold"},  acc_out,   exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    vec_len  = '0;
    in_valid = 1'b0;
    a_in     = '0;
    w_in     = '0;
`ifdef ACC_BIAS_EN
    bias_in  = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready,  0);
    check("rst_valid", acc_valid, 0);
    check("rst_out",   acc_out,   0);
    check("rst_ovf",   acc_ovf,   0);
    check("rst_busy",  busy,      0);
    rst = 1'b0;
    @(negedge clk);

    // T1: 2 + 12 - 30 - 56 = -72
    set_pair(0, 1, 2); set_pair(1, 3, 4); set_pair(2, -5, 6); set_pair(3, 7, -8);
    run_vector("t1", 4, 1'b0, 1'b0, -72, 0);

    // T2a: 4 * 16384 = 65536 -> +32767
    for (int i = 0; i < 4; i++) set_pair(i, -128, -128);
    run_vector("t2a", 4, 1'b0, 1'b0, 32767, 1);
    // T2b: 3 * -16256 = -48768 -> -32768
    for (int i = 0; i < 3; i++) set_pair(i, 127, -128);
    run_vector("t2b", 3, 1'b0, 1'b0, -32768, 1);
    // T2c: 32768 - 1 = 32767 sits exactly on the rail, so no clamp
    set_pair(0, -128, -128); set_pair(1, -128, -128); set_pair(2, -1, 1);
    run_vector("t2c", 3, 1'b0, 1'b0, 32767, 0);
    // T2d: 2 * 16384 = 32768 is one past the rail
    run_vector("t2d", 2, 1'b0, 1'b0, 32767, 1);

    // T3: T1 pairs with idle cycles in between
    set_pair(0, 1, 2); set_pair(1, 3, 4); set_pair(2, -5, 6); set_pair(3, 7, -8);
    run_vector("t3", 4, 1'b1, 1'b0, -72, 0);

    // T4: an empty vector yields 0, then start pulses inside a vector are ignored
    run_vector("t4a", 0, 1'b0, 1'b0, 0, 0);
    run_vector("t4b", 4, 1'b0, 1'b1, -72, 0);

    // T5: reset after 2 of 4 pairs discards the vector
    start   = 1'b1;
    vec_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_in     = 8'd50;
      w_in     = 8'd50;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("t5_busy",  busy,      0);
    check("t5_rdy",   in_ready,  0);
    check("t5_valid", acc_valid, 0);
    check("t5_out",   acc_out,   0);
    rst      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5_quiet%0d", i), acc_valid, 0);
      check($sformatf("t5_noacc%0d", i), busy, 0);
    end
    in_valid = 1'b0;
    set_pair(0, 5, 5);
    run_vector("t5b", 1, 1'b0, 1'b0, 25, 0);

`ifdef ACC_BIAS_EN
    // T6: the bias preloads the accumulator
    bias_in = 16'd100;
    set_pair(0, 1, 2); set_pair(1, 3, 4); set_pair(2, -5, 6); set_pair(3, 7, -8);
    run_vector("t6a", 4, 1'b0, 1'b0, 28, 0);
    bias_in = 16'd32700;
    set_pair(0, 10, 10);
    run_vector("t6b", 1, 1'b0, 1'b0, 32767, 1);
    bias_in = 16'hFF9C;  // -100
    run_vector("t6c", 0, 1'b0, 1'b0, -100, 0);
    bias_in = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
